// File: rtl/eth_stream_checker.sv
// eth_stream_checker: on-chip scoreboard that compares the eth_rx app stream against queued expected beats.
// Build option: define ETH_CHECKER_DEBUG_ID_EN to store a debug id per expected beat and report it on mismatch.
module eth_stream_checker #(
    parameter int DATA_W     = 16,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int LEN_W      = $clog2(KEEP_W + 1),
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16
`ifdef ETH_CHECKER_DEBUG_ID_EN
    ,
    parameter int DEBUG_ID_W = 32
`endif
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clr_i,
    input  logic              exp_valid_i,
    output logic              exp_ready_o,
    input  logic              exp_start_i,
    input  logic [LEN_W-1:0]  exp_len_i,
    input  logic [DATA_W-1:0] exp_data_i,
`ifdef ETH_CHECKER_DEBUG_ID_EN
    input  logic [DEBUG_ID_W-1:0] exp_id_i,
    output logic [DEBUG_ID_W-1:0] err_id_o,
`endif
    input  logic              app_valid_i,
    input  logic              app_start_i,
    input  logic              app_cancel_i,
    input  logic [LEN_W-1:0]  app_len_i,
    input  logic [DATA_W-1:0] app_data_i,
    output logic              mismatch_o,
    output logic              underflow_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  pkt_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_fifo_start [DEPTH];
    logic [LEN_W-1:0]  r_fifo_len   [DEPTH];
    logic [DATA_W-1:0] r_fifo_data  [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    logic              r_mismatch;
    logic              r_underflow;
    logic              r_err;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_beat;
    logic              w_cancel;
    logic              w_cmp;
    logic              w_force_mm;
    logic              w_mismatch;
    logic              w_underflow;
    logic              w_err_evt;
    logic              w_pkt_inc;
    logic              w_head_start;
    logic [LEN_W-1:0]  w_head_len;
    logic [DATA_W-1:0] w_head_data;
    logic              w_data_eq;
    logic              w_match;

    // Extra wrap bit distinguishes full (wrap differs) from empty (pointers identical).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = exp_valid_i && !w_full;

    assign w_beat   = app_valid_i && !app_cancel_i;
    assign w_cancel = app_valid_i && app_cancel_i;

    assign w_head_start = r_fifo_start[r_rd_ptr[AW-1:0]];
    assign w_head_len   = r_fifo_len[r_rd_ptr[AW-1:0]];
    assign w_head_data  = r_fifo_data[r_rd_ptr[AW-1:0]];

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_data_eq = 1'b1;
        for (int i = 0; i < KEEP_W; i++) begin
            if (i < int'(w_head_len) && app_data_i[8*i +: 8] != w_head_data[8*i +: 8]) begin
                w_data_eq = 1'b0;
            end
        end
    end

    assign w_match = (app_start_i == w_head_start) && (app_len_i == w_head_len) && w_data_eq;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cmp       = 1'b0;
        w_force_mm  = 1'b0;
        w_underflow = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    if (w_empty) begin
                        w_underflow = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        w_cmp = 1'b1;
                        if (app_start_i) begin
                            w_state_nxt = ST_PKT;
                        end else begin
                            w_force_mm = 1'b1;
                        end
                    end
                end
            end
            ST_PKT: begin
                if (w_cancel) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_beat) begin
                    if (w_empty) begin
                        w_underflow = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        w_cmp = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_beat) begin
                    if (w_empty) begin
                        w_underflow = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (app_start_i && w_head_start) begin
                        w_pop       = 1'b1;
                        w_cmp       = 1'b1;
                        w_state_nxt = ST_PKT;
                    end else begin
                        // Stray beat while resynchronising: flagged, head entry kept.
                        w_force_mm  = 1'b1;
                        w_state_nxt = w_head_start ? ST_IDLE : ST_DRAIN;
                    end
                end else if (w_empty || w_head_start) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pop = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_mismatch = w_force_mm || (w_cmp && !w_match);
    assign w_err_evt  = w_mismatch || w_underflow;
    assign w_pkt_inc  = w_cmp && w_match && !w_force_mm && app_start_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: storage is not reset; the pointer reset alone empties the FIFO and keeps the array in plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_start[r_wr_ptr[AW-1:0]] <= exp_start_i;
            r_fifo_len[r_wr_ptr[AW-1:0]]   <= exp_len_i;
            r_fifo_data[r_wr_ptr[AW-1:0]]  <= exp_data_i;
        end
    end

    // A clear coinciding with an event leaves that event counted.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mismatch  <= 1'b0;
            r_underflow <= 1'b0;
            r_err       <= 1'b0;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_mismatch  <= w_mismatch;
            r_underflow <= w_underflow;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end else if (clr_i) begin
                r_err <= 1'b0;
            end
            if (clr_i) begin
                r_err_cnt <= w_err_evt ? CNT_W'(1) : '0;
                r_pkt_cnt <= w_pkt_inc ? CNT_W'(1) : '0;
            end else begin
                if (w_err_evt && r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                if (w_pkt_inc && r_pkt_cnt != '1) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef ETH_CHECKER_DEBUG_ID_EN
    logic [DEBUG_ID_W-1:0] r_fifo_id [DEPTH];
    logic [DEBUG_ID_W-1:0] r_err_id;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr[AW-1:0]] <= exp_id_i;
        end
    end

    // A mismatch always has a head entry; underflows leave the last id in place.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_err_id <= '0;
        end else if (w_mismatch) begin
            r_err_id <= r_fifo_id[r_rd_ptr[AW-1:0]];
        end
    end

    assign err_id_o = r_err_id;
`endif

    assign exp_ready_o = !w_full;
    assign mismatch_o  = r_mismatch;
    assign underflow_o = r_underflow;
    assign err_o       = r_err;
    assign pkt_cnt_o   = r_pkt_cnt;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_eth_stream_checker.sv
// Directed bench for eth_stream_checker: expected pulses are queued per observed beat and checked one cycle later.
`timescale 1ns/1ps
module tb_eth_stream_checker;

    localparam int DATA_W     = 16;
    localparam int LEN_W      = 2;
    localparam int DEPTH      = 16;
    localparam int CNT_W      = 4;
    localparam int DEBUG_ID_W = 32;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              clr_i = 1'b0;
    logic              exp_valid_i = 1'b0;
    logic              exp_ready_o;
    logic              exp_start_i = 1'b0;
    logic [LEN_W-1:0]  exp_len_i = '0;
    logic [DATA_W-1:0] exp_data_i = '0;
    logic              app_valid_i = 1'b0;
    logic              app_start_i = 1'b0;
    logic              app_cancel_i = 1'b0;
    logic [LEN_W-1:0]  app_len_i = '0;
    logic [DATA_W-1:0] app_data_i = '0;
    logic              mismatch_o;
    logic              underflow_o;
    logic              err_o;
    logic [CNT_W-1:0]  pkt_cnt_o;
    logic [CNT_W-1:0]  err_cnt_o;
`ifdef ETH_CHECKER_DEBUG_ID_EN
    logic [DEBUG_ID_W-1:0] exp_id_i = '0;
    logic [DEBUG_ID_W-1:0] err_id_o;
`endif

    always #5 clk = ~clk;

    eth_stream_checker #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
`ifdef ETH_CHECKER_DEBUG_ID_EN
        ,
        .DEBUG_ID_W (DEBUG_ID_W)
`endif
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .clr_i        (clr_i),
        .exp_valid_i  (exp_valid_i),
        .exp_ready_o  (exp_ready_o),
        .exp_start_i  (exp_start_i),
        .exp_len_i    (exp_len_i),
        .exp_data_i   (exp_data_i),
`ifdef ETH_CHECKER_DEBUG_ID_EN
        .exp_id_i     (exp_id_i),
        .err_id_o     (err_id_o),
`endif
        .app_valid_i  (app_valid_i),
        .app_start_i  (app_start_i),
        .app_cancel_i (app_cancel_i),
        .app_len_i    (app_len_i),
        .app_data_i   (app_data_i),
        .mismatch_o   (mismatch_o),
        .underflow_o  (underflow_o),
        .err_o        (err_o),
        .pkt_cnt_o    (pkt_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    typedef struct packed {
        logic mm;
        logic uf;
    } pulse_t;

    pulse_t           sb_q[$];
    int               n_pass  = 0;
    int               n_total = 0;
    logic [CNT_W-1:0] m_err_cnt = '0;
    logic [CNT_W-1:0] m_pkt_cnt = '0;
    logic             m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [LEN_W-1:0] ln, input logic [DATA_W-1:0] d,
                        input logic [31:0] id);
        exp_valid_i = 1'b1;
        exp_start_i = st;
        exp_len_i   = ln;
        exp_data_i  = d;
`ifdef ETH_CHECKER_DEBUG_ID_EN
        exp_id_i    = id;
`endif
        step();
        exp_valid_i = 1'b0;
    endtask

    task automatic check_pulses(input string tag);
        pulse_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_mismatch"}, 32'(mismatch_o), 32'(e.mm));
            check({tag, "_underflow"}, 32'(underflow_o), 32'(e.uf));
        end
    endtask

    // Observed beat with its expected outcome; the model counters follow from that outcome.
    task automatic obs(input string tag, input logic st, input logic [LEN_W-1:0] ln,
                       input logic [DATA_W-1:0] d, input logic emm, input logic euf);
        logic evt;
        logic pk;
        evt = emm | euf;
        pk  = !evt && st;
        app_valid_i = 1'b1;
        app_start_i = st;
        app_len_i   = ln;
        app_data_i  = d;
        sb_q.push_back('{mm: emm, uf: euf});
        if (clr_i) begin
            m_err_cnt = evt ? CNT_W'(1) : '0;
            m_pkt_cnt = pk ? CNT_W'(1) : '0;
            m_err     = evt;
        end else begin
            if (evt && m_err_cnt != '1) m_err_cnt = m_err_cnt + CNT_W'(1);
            if (pk && m_pkt_cnt != '1) m_pkt_cnt = m_pkt_cnt + CNT_W'(1);
            m_err = m_err | evt;
        end
        step();
        app_valid_i = 1'b0;
        check_pulses(tag);
        check({tag, "_err"}, 32'(err_o), 32'(m_err));
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'(m_err_cnt));
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt_o), 32'(m_pkt_cnt));
    endtask

    task automatic cancel(input string tag);
        app_valid_i  = 1'b1;
        app_cancel_i = 1'b1;
        sb_q.push_back('{mm: 1'b0, uf: 1'b0});
        step();
        app_valid_i  = 1'b0;
        app_cancel_i = 1'b0;
        check_pulses(tag);
    endtask

    task automatic clear(input string tag);
        clr_i = 1'b1;
        step();
        clr_i     = 1'b0;
        m_err_cnt = '0;
        m_pkt_cnt = '0;
        m_err     = 1'b0;
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt_o), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mismatch"}, 32'(mismatch_o), 32'd0);
        check({tag, "_underflow"}, 32'(underflow_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt_o), 32'd0);
        check({tag, "_ready"}, 32'(exp_ready_o), 32'd1);
`ifdef ETH_CHECKER_DEBUG_ID_EN
        check({tag, "_err_id"}, err_id_o, 32'd0);
`endif
    endtask

    initial begin
        // Reset
        #12;
        check_reset("rst");
        nreset = 1'b1;
        step();

        // Multi-beat packet; byte above len on the last beat differs and is ignored; cancel in IDLE ignored
        push(1'b1, 2'd2, 16'hAAAA, 32'h11);
        push(1'b0, 2'd2, 16'hBBBB, 32'h12);
        push(1'b0, 2'd1, 16'h11CC, 32'h13);
        cancel("t1_idle_cancel");
        obs("t1_b0", 1'b1, 2'd2, 16'hAAAA, 1'b0, 1'b0);
        obs("t1_b1", 1'b0, 2'd2, 16'hBBBB, 1'b0, 1'b0);
        obs("t1_b2", 1'b0, 2'd1, 16'h22CC, 1'b0, 1'b0);

        // Data mismatch in low byte
        push(1'b1, 2'd2, 16'h1235, 32'h55);
        obs("t5_data", 1'b1, 2'd2, 16'h1234, 1'b1, 1'b0);
`ifdef ETH_CHECKER_DEBUG_ID_EN
        check("t5_err_id", err_id_o, 32'h55);
`endif

        // Underflow, clear racing an underflow, then a plain clear
        obs("t2_uf", 1'b1, 2'd2, 16'h0000, 1'b0, 1'b1);
        clr_i = 1'b1;
        obs("t2_clr_race", 1'b1, 2'd1, 16'h0000, 1'b0, 1'b1);
        clr_i = 1'b0;
        clear("t2_clr");

        // Cancel mid-packet drains the rest of A, then B is checked cleanly
        push(1'b1, 2'd2, 16'h0A01, 32'h21);
        push(1'b0, 2'd2, 16'h0A02, 32'h22);
        push(1'b0, 2'd1, 16'h0A03, 32'h23);
        push(1'b1, 2'd2, 16'h0B01, 32'h24);
        push(1'b0, 2'd2, 16'h0B02, 32'h25);
        obs("t4_a0", 1'b1, 2'd2, 16'h0A01, 1'b0, 1'b0);
        cancel("t4_cancel");
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_drain_quiet", 32'(mismatch_o | underflow_o), 32'd0);
        end
        obs("t4_b0", 1'b1, 2'd2, 16'h0B01, 1'b0, 1'b0);
        obs("t4_b1", 1'b0, 2'd2, 16'h0B02, 1'b0, 1'b0);

        // Fill to DEPTH; push during a pop while full is refused
        for (int i = 0; i < DEPTH; i++) begin
            push(1'b1, 2'd0, 16'(i), 32'(i));
        end
        check("t3_full_ready", 32'(exp_ready_o), 32'd0);
        exp_valid_i = 1'b1;
        exp_start_i = 1'b1;
        exp_len_i   = 2'd0;
        obs("t3_push_pop", 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0);
        exp_valid_i = 1'b0;
        check("t3_ready_after", 32'(exp_ready_o), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            obs("t3_pop", 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0);
        end
        obs("t3_empty", 1'b1, 2'd0, 16'h0000, 1'b0, 1'b1);

        // Error counter saturation
        for (int i = 0; i < 17; i++) begin
            obs("t6_sat", 1'b1, 2'd0, 16'h0000, 1'b0, 1'b1);
        end
        check("t6_sat_final", 32'(err_cnt_o), 32'hF);

        // Asynchronous reset mid-packet flushes the FIFO and returns to IDLE
        push(1'b1, 2'd2, 16'h0601, 32'h31);
        push(1'b0, 2'd2, 16'h0602, 32'h32);
        obs("t6_pkt", 1'b1, 2'd2, 16'h0601, 1'b0, 1'b0);
        #2;
        nreset = 1'b0;
        #1;
        check_reset("t6_rst");
        m_err_cnt = '0;
        m_pkt_cnt = '0;
        m_err     = 1'b0;
        #2;
        nreset = 1'b1;
        step();
        obs("t6_flushed", 1'b0, 2'd2, 16'h0602, 1'b0, 1'b1);
        push(1'b0, 2'd1, 16'h00AA, 32'h41);
        obs("t6_idle_nostart", 1'b0, 2'd1, 16'h00AA, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
